// File: rtl/hippo_memory_interleaved.sv
// hippo_memory_interleaved: byte-interleaved load/store memory.
// Lanes byte-wide banks side by side; any byte/half/word access, including
// one that straddles into the next row, completes in a single bank cycle.
// Valid/ready request and response channels, one transaction in flight.
module hippo_memory_interleaved #(
  parameter int Depth     = 256,
  parameter int Lanes     = 4,
  parameter int AddrWidth = $clog2(Depth*Lanes),
  parameter bit Writeable = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic                 signed_i,
  input  logic [8*Lanes-1:0]   data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [8*Lanes-1:0]   data_o,
  output logic                 err_o
);

  localparam int LaneW = $clog2(Lanes);
  localparam int RowW  = AddrWidth - LaneW;

  // ---- stage p0: request decode, bank access at the accept edge ----
  logic                 accept_p0;
  logic                 err_p0;
  logic [LaneW-1:0]     off_p0;
  logic [RowW-1:0]      row_p0;
  logic [RowW-1:0]      row_nxt_p0;
  logic [LaneW:0]       nbytes_p0;
  logic [Lanes-1:0]     lane_en_p0;
  logic [RowW-1:0]      lane_row_p0   [Lanes];
  logic [7:0]           lane_wdata_p0 [Lanes];

  // ---- stage p1: response state ----
  logic                 rsp_valid_p1;
  logic                 err_p1;
  logic                 isrd_p1;
  logic [LaneW-1:0]     off_p1;
  logic [1:0]           size_p1;
  logic                 signed_p1;
  logic [8*Lanes-1:0]   rd_bus_p1;

  assign req_ready_o = !rsp_valid_p1 || rsp_ready_i;
  // Nothing may be accepted (and no bank written) while reset is held.
  assign accept_p0   = req_valid_i && req_ready_o && rst_i;
  assign err_p0      = (size_i == 2'd3) || (we_i && !Writeable);
  assign off_p0      = addr_i[LaneW-1:0];
  assign row_p0      = addr_i[AddrWidth-1:LaneW];

  // Map access byte k onto lane (off+k) mod Lanes; lanes below off belong to the next row.
  always_comb begin
    logic [LaneW-1:0] k;
    k          = '0;
    nbytes_p0  = {{LaneW{1'b0}}, 1'b1} << size_i;
    row_nxt_p0 = (row_p0 == RowW'(Depth-1)) ? '0 : row_p0 + 1'b1;
    for (int l = 0; l < Lanes; l++) begin
      k                = LaneW'(l) - off_p0;
      lane_en_p0[l]    = ({1'b0, k} < nbytes_p0);
      lane_row_p0[l]   = (LaneW'(l) < off_p0) ? row_nxt_p0 : row_p0;
      lane_wdata_p0[l] = data_i[{k, 3'b000} +: 8];
    end
  end

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    logic [7:0] bank [Depth];
    logic [7:0] rd_p1;

    // Byte bank: write or registered read of this lane's row at the accept edge.
    always_ff @(posedge clk_i) begin
      if (accept_p0 && !err_p0 && lane_en_p0[l]) begin
        if (we_i) bank[lane_row_p0[l]] <= lane_wdata_p0[l];
        else      rd_p1                <= bank[lane_row_p0[l]];
      end
    end

    assign rd_bus_p1[8*l +: 8] = rd_p1;
  end

  // Response state: load on accept, clear once consumed with nothing new behind it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid_p1 <= 1'b0;
      err_p1       <= 1'b0;
      isrd_p1      <= 1'b0;
      off_p1       <= '0;
      size_p1      <= '0;
      signed_p1    <= 1'b0;
    end else if (accept_p0) begin
      rsp_valid_p1 <= 1'b1;
      err_p1       <= err_p0;
      isrd_p1      <= !we_i && !err_p0;
      off_p1       <= off_p0;
      size_p1      <= size_i;
      signed_p1    <= signed_i;
    end else if (rsp_ready_i) begin
      rsp_valid_p1 <= 1'b0;
    end
  end

  // Rotate lane bytes back to LSB-aligned order and extend the unused upper bytes.
  always_comb begin
    logic [LaneW-1:0] lane;
    logic [LaneW-1:0] lane1;
    logic [LaneW:0]   nbytes;
    logic             fill;
    data_o = '0;
    lane   = '0;
    lane1  = off_p1 + 1'b1;
    nbytes = {{LaneW{1'b0}}, 1'b1} << size_p1;
    fill   = 1'b0;
    if (signed_p1 && (size_p1 == 2'd0)) fill = rd_bus_p1[{off_p1, 3'b111}];
    if (signed_p1 && (size_p1 == 2'd1)) fill = rd_bus_p1[{lane1, 3'b111}];
    if (rsp_valid_p1 && isrd_p1) begin
      for (int k = 0; k < Lanes; k++) begin
        lane = off_p1 + LaneW'(k);
        if ((LaneW+1)'(k) < nbytes) data_o[8*k +: 8] = rd_bus_p1[{lane, 3'b000} +: 8];
        else                        data_o[8*k +: 8] = {8{fill}};
      end
    end
  end

  assign rsp_valid_o = rsp_valid_p1;
  assign err_o       = rsp_valid_p1 && err_p1;

endmodule

// File: tb/tb_hippo_memory_interleaved.sv
// Directed bench for hippo_memory_interleaved. Three instances share one
// stimulus stream: A (default), B (Depth=4, row wrap), C (Writeable=0).
module tb_hippo_memory_interleaved;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        we = 1'b0;
  logic        sgn = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [9:0]  addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] wdata = '0;

  logic        rdy_a, rv_a, er_a;
  logic [31:0] do_a;
  logic        rdy_b, rv_b, er_b;
  logic [31:0] do_b;
  logic        rdy_c, rv_c, er_c;
  logic [31:0] do_c;

  int errors = 0;
  int checks = 0;
  logic [31:0] before_c;
  logic [31:0] exp_stream [4];

  always #5 clk = ~clk;

  hippo_memory_interleaved #(.Depth(256), .Lanes(4)) u_a (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_a),
    .addr_i(addr), .we_i(we), .size_i(size), .signed_i(sgn), .data_i(wdata),
    .rsp_valid_o(rv_a), .rsp_ready_i(rsp_ready), .data_o(do_a), .err_o(er_a));

  hippo_memory_interleaved #(.Depth(4), .Lanes(4)) u_b (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_b),
    .addr_i(addr[3:0]), .we_i(we), .size_i(size), .signed_i(sgn), .data_i(wdata),
    .rsp_valid_o(rv_b), .rsp_ready_i(rsp_ready), .data_o(do_b), .err_o(er_b));

  hippo_memory_interleaved #(.Depth(256), .Lanes(4), .Writeable(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_c),
    .addr_i(addr), .we_i(we), .size_i(size), .signed_i(sgn), .data_i(wdata),
    .rsp_valid_o(rv_c), .rsp_ready_i(rsp_ready), .data_o(do_c), .err_o(er_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at the falling edge; it is accepted at the next rising edge
  // and the response is sampled 1 time unit later.
  task automatic issue(input logic [9:0] a, input logic w, input logic [1:0] s,
                       input logic sg, input logic [31:0] d);
    @(negedge clk);
    addr = a; we = w; size = s; sgn = sg; wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [9:0] a, input logic [1:0] s,
                      input logic sg, input logic [31:0] exp);
    issue(a, 1'b0, s, sg, 32'h0);
    check({tag, ".vld"}, {30'h0, rv_a, er_a}, 32'h2);
    check(tag, do_a, exp);
  endtask

  task automatic wr_a(input string tag, input logic [9:0] a, input logic [1:0] s,
                      input logic [31:0] d);
    issue(a, 1'b1, s, 1'b0, d);
    check({tag, ".rsp"}, {30'h0, rv_a, er_a}, 32'h2);
    check({tag, ".dat"}, do_a, 32'h0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst.rv",  {31'h0, rv_a}, 32'h0);
    check("rst.err", {31'h0, er_a}, 32'h0);
    check("rst.dat", do_a, 32'h0);
    check("rst.rdy", {31'h0, rdy_a}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word write then byte reads
    wr_a("w0", 10'h000, 2'd2, 32'hDDCCBBAA);
    rd_a("b0", 10'h000, 2'd0, 1'b0, 32'h000000AA);
    rd_a("b1", 10'h001, 2'd0, 1'b0, 32'h000000BB);
    rd_a("b2", 10'h002, 2'd0, 1'b0, 32'h000000CC);
    rd_a("b3", 10'h003, 2'd0, 1'b0, 32'h000000DD);

    // Straddling word write across rows 1/2
    wr_a("w4", 10'h004, 2'd2, 32'h01020304);
    wr_a("w8", 10'h008, 2'd2, 32'h05060708);
    wr_a("w6", 10'h006, 2'd2, 32'h44332211);
    rd_a("r4", 10'h004, 2'd2, 1'b0, 32'h22110304);
    rd_a("r8", 10'h008, 2'd2, 1'b0, 32'h05064433);
    rd_a("r6", 10'h006, 2'd2, 1'b0, 32'h44332211);

    // Half write, signed/unsigned extension
    wr_a("h1", 10'h001, 2'd1, 32'h00008001);
    rd_a("h1s", 10'h001, 2'd1, 1'b1, 32'hFFFF8001);
    rd_a("h1u", 10'h001, 2'd1, 1'b0, 32'h00008001);
    rd_a("b0k", 10'h000, 2'd0, 1'b0, 32'h000000AA);
    rd_a("b3k", 10'h003, 2'd0, 1'b0, 32'h000000DD);
    rd_a("b0s", 10'h000, 2'd0, 1'b1, 32'hFFFFFFAA);
    rd_a("h6s", 10'h006, 2'd1, 1'b1, 32'h00002211);
    rd_a("h7s", 10'h007, 2'd1, 1'b1, 32'h00003322);

    // Last-row wrap on the Depth=4 instance
    issue(10'h00E, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D);
    check("wrap.w", {30'h0, rv_b, er_b}, 32'h2);
    issue(10'h00E, 1'b0, 2'd0, 1'b0, 32'h0);
    check("wrap.bE", do_b, 32'h0000000D);
    issue(10'h00F, 1'b0, 2'd0, 1'b0, 32'h0);
    check("wrap.bF", do_b, 32'h000000F0);
    issue(10'h000, 1'b0, 2'd0, 1'b0, 32'h0);
    check("wrap.b0", do_b, 32'h000000FE);
    issue(10'h001, 1'b0, 2'd0, 1'b0, 32'h0);
    check("wrap.b1", do_b, 32'h000000CA);
    issue(10'h00E, 1'b0, 2'd2, 1'b0, 32'h0);
    check("wrap.wB", do_b, 32'hCAFEF00D);
    check("nowrap.wA", do_a, 32'hCAFEF00D);

    // Backpressure: stall three cycles, then a back-to-back stream
    rd_a("bp.first", 10'h006, 2'd2, 1'b0, 32'h44332211);
    @(negedge clk);
    rsp_ready = 1'b0;
    addr = 10'h000; we = 1'b0; size = 2'd0; sgn = 1'b0; req_valid = 1'b1;
    #1;
    check("bp.rdy0", {31'h0, rdy_a}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp.rdy", {31'h0, rdy_a}, 32'h0);
      check("bp.rv", {31'h0, rv_a}, 32'h1);
      check("bp.hold", do_a, 32'h44332211);
    end
    exp_stream[0] = 32'h000000AA;
    exp_stream[1] = 32'h00000001;
    exp_stream[2] = 32'h00000080;
    exp_stream[3] = 32'h000000DD;
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 10'(i);
      @(posedge clk);
      #1;
      check("bp.srv", {31'h0, rv_a}, 32'h1);
      check("bp.sdat", do_a, exp_stream[i]);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp.drop", {31'h0, rv_a}, 32'h0);

    // Illegal size: error response, no bank change
    issue(10'h000, 1'b1, 2'd3, 1'b0, 32'h11111111);
    check("sz3w.err", {30'h0, rv_a, er_a}, 32'h3);
    check("sz3w.dat", do_a, 32'h0);
    issue(10'h000, 1'b0, 2'd3, 1'b1, 32'h0);
    check("sz3r.err", {30'h0, rv_a, er_a}, 32'h3);
    check("sz3r.dat", do_a, 32'h0);
    rd_a("sz3.keep", 10'h000, 2'd2, 1'b0, 32'hDD8001AA);

    // Read-only instance rejects writes
    issue(10'h020, 1'b0, 2'd2, 1'b0, 32'h0);
    check("ro.rd0", {30'h0, rv_c, er_c}, 32'h2);
    before_c = do_c;
    issue(10'h020, 1'b1, 2'd2, 1'b0, 32'h5A5A5A5A);
    check("ro.werr", {30'h0, rv_c, er_c}, 32'h3);
    check("ro.wdat", do_c, 32'h0);
    check("rw.werr", {30'h0, rv_a, er_a}, 32'h2);
    issue(10'h020, 1'b0, 2'd2, 1'b0, 32'h0);
    check("ro.keep", do_c, before_c);
    check("rw.new", do_a, 32'h5A5A5A5A);

    // Reset while a response is pending
    rd_a("rst.pre", 10'h000, 2'd2, 1'b0, 32'hDD8001AA);
    @(negedge clk);
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.rv",  {31'h0, rv_a}, 32'h0);
    check("arst.dat", do_a, 32'h0);
    check("arst.err", {31'h0, er_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    rd_a("post.rst", 10'h000, 2'd2, 1'b0, 32'hDD8001AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
